// File: rtl/esdes_decrypt_iter.sv
// Iterative ESDES decryptor. It recovers the 8-bit nonce from an ESDES ciphertext and the
// 10-bit key.
// The block computes one Feistel round per clock and shares a single round-function
// instance between the rounds.
// Handshake: valid/ready on input, valid/ready on output, one word in flight at a time.
// Optional build macro: ESDES_DEC_SELFCHECK_EN. It adds a CHK state that re-encrypts the
// recovered nonce and flags a mismatch against the latched ciphertext on chk_err.
module esdes_decrypt_iter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] ct,
  input  logic [9:0] key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pt,
`ifdef ESDES_DEC_SELFCHECK_EN
  output logic       chk_err,
`endif
  output logic       busy
);

  // ---------------------------------------------------------------------------
  // Cipher primitives
  // ---------------------------------------------------------------------------

  function automatic logic [7:0] p8(input logic [7:0] v);
    return {v[6], v[2], v[5], v[7], v[4], v[0], v[3], v[1]};
  endfunction

  function automatic logic [7:0] q8(input logic [7:0] v);
    return {v[4], v[7], v[5], v[3], v[1], v[6], v[0], v[2]};
  endfunction

  function automatic logic [7:0] subkey1(input logic [9:0] ki);
    return {ki[9], ki[3], ki[1], ki[6], ki[2], ki[7], ki[0], ki[4]};
  endfunction

  function automatic logic [7:0] subkey2(input logic [9:0] ki);
    return {ki[2], ki[7], ki[4], ki[5], ki[0], ki[8], ki[1], ki[9]};
  endfunction

  function automatic logic [1:0] sbox0(input logic [3:0] idx);
    logic [1:0] r;
    case (idx)
      4'd0:  r = 2'd1;
      4'd1:  r = 2'd3;
      4'd2:  r = 2'd0;
      4'd3:  r = 2'd2;
      4'd4:  r = 2'd3;
      4'd5:  r = 2'd1;
      4'd6:  r = 2'd2;
      4'd7:  r = 2'd0;
      4'd8:  r = 2'd0;
      4'd9:  r = 2'd3;
      4'd10: r = 2'd2;
      4'd11: r = 2'd1;
      4'd12: r = 2'd1;
      4'd13: r = 2'd3;
      4'd14: r = 2'd3;
      default: r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sbox1(input logic [3:0] idx);
    logic [1:0] r;
    case (idx)
      4'd0:  r = 2'd0;
      4'd1:  r = 2'd2;
      4'd2:  r = 2'd1;
      4'd3:  r = 2'd0;
      4'd4:  r = 2'd2;
      4'd5:  r = 2'd1;
      4'd6:  r = 2'd3;
      4'd7:  r = 2'd3;
      4'd8:  r = 2'd3;
      4'd9:  r = 2'd2;
      4'd10: r = 2'd0;
      4'd11: r = 2'd1;
      4'd12: r = 2'd1;
      4'd13: r = 2'd0;
      4'd14: r = 2'd0;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] f_round(input logic [3:0] x, input logic [7:0] k);
    logic [7:0] e;
    logic [3:0] a;
    e = {x[0], x[3], x[2], x[1], x[2], x[1], x[0], x[3]} ^ k;
    a = {sbox0(e[7:4]), sbox1(e[3:0])};
    return {a[2], a[0], a[1], a[3]};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

`ifdef ESDES_DEC_SELFCHECK_EN
  typedef enum logic [2:0] {StIdle, StR1, StR2, StChk, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StR1, StR2, StDone} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] f_q;   // P8(~ct): {H, L1}
  // The two subkeys together cover every key bit, so they are the latched copy of the key.
  logic [7:0] k1_q;
  logic [7:0] k2_q;
  logic [3:0] r_q;
  logic [7:0] pt_q;

  logic [3:0] round_x;
  logic [7:0] round_k;
  logic [3:0] round_f;
  logic [9:0] key_inv;

`ifdef ESDES_DEC_SELFCHECK_EN
  logic [7:0] ct_q;
  logic [3:0] chk_l1_q;
  logic       chk_phase_q;
  logic       chk_err_q;
  logic [7:0] chk_lr;  // P8(~pt): {L, R} as seen by the re-encryption
`endif

  assign key_inv = ~key;

`ifdef ESDES_DEC_SELFCHECK_EN
  assign chk_lr  = p8(~pt_q);
  assign chk_err = chk_err_q;
`endif

  // Route the operands of the current round into the shared round function.
  always_comb begin
    round_x = 4'h0;
    round_k = 8'h00;
    unique case (state_q)
      StR1: begin
        round_x = f_q[3:0];
        round_k = k2_q;
      end
      StR2: begin
        round_x = r_q;
        round_k = k1_q;
      end
`ifdef ESDES_DEC_SELFCHECK_EN
      StChk: begin
        round_x = chk_phase_q ? chk_l1_q : chk_lr[3:0];
        round_k = chk_phase_q ? k2_q : k1_q;
      end
`endif
      default: begin
        round_x = 4'h0;
        round_k = 8'h00;
      end
    endcase
    round_f = f_round(round_x, round_k);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = StR1;
        end
      end
      StR1: state_d = StR2;
`ifdef ESDES_DEC_SELFCHECK_EN
      StR2: state_d = StChk;
      StChk: begin
        if (chk_phase_q) begin
          state_d = StDone;
        end
      end
`else
      StR2: state_d = StDone;
`endif
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: operands on accept, one round result per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q         <= 8'h00;
      k1_q        <= 8'h00;
      k2_q        <= 8'h00;
      r_q         <= 4'h0;
      pt_q        <= 8'h00;
`ifdef ESDES_DEC_SELFCHECK_EN
      ct_q        <= 8'h00;
      chk_l1_q    <= 4'h0;
      chk_phase_q <= 1'b0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            f_q         <= p8(~ct);
            k1_q        <= subkey1(key_inv);
            k2_q        <= subkey2(key_inv);
`ifdef ESDES_DEC_SELFCHECK_EN
            ct_q        <= ct;
            chk_phase_q <= 1'b0;
            chk_err_q   <= 1'b0;
`endif
          end
        end
        // Round A: R = H ^ F(L1, K2)
        StR1: r_q <= f_q[7:4] ^ round_f;
        // Round B: L = L1 ^ F(R, K1), then undo the input permutation
        StR2: pt_q <= ~q8({f_q[3:0] ^ round_f, r_q});
`ifdef ESDES_DEC_SELFCHECK_EN
        // Re-encrypt: L1' = L ^ F(R, K1), then H' = R ^ F(L1', K2)
        StChk: begin
          if (!chk_phase_q) begin
            chk_l1_q    <= chk_lr[7:4] ^ round_f;
            chk_phase_q <= 1'b1;
          end else begin
            chk_err_q   <= (~q8({chk_lr[3:0] ^ round_f, chk_l1_q})) != ct_q;
            chk_phase_q <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign pt = pt_q;

endmodule

// File: tb/tb_esdes_decrypt_iter.sv
// Self-checking bench for esdes_decrypt_iter. The reference model is built from permutation
// index maps and S-box lookup arrays.
// Build with ESDES_DEC_SELFCHECK_EN defined to exercise the self-check variant.
module tb_esdes_decrypt_iter;

`ifdef ESDES_DEC_SELFCHECK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ct;
  logic [9:0] key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pt;
  logic       busy;
`ifdef ESDES_DEC_SELFCHECK_EN
  logic       chk_err;
`endif

  esdes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
`ifdef ESDES_DEC_SELFCHECK_EN
    .chk_err   (chk_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef logic [7:0][2:0] pmap_t;  // out bit i takes source bit map[i]
  typedef logic [7:0][3:0] kmap_t;
  typedef logic [7:0][1:0] emap_t;
  typedef logic [3:0][1:0] omap_t;

  localparam pmap_t P8_MAP = {3'd6, 3'd2, 3'd5, 3'd7, 3'd4, 3'd0, 3'd3, 3'd1};
  localparam kmap_t K1_MAP = {4'd9, 4'd3, 4'd1, 4'd6, 4'd2, 4'd7, 4'd0, 4'd4};
  localparam kmap_t K2_MAP = {4'd2, 4'd7, 4'd4, 4'd5, 4'd0, 4'd8, 4'd1, 4'd9};
  localparam emap_t E_MAP  = {2'd0, 2'd3, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
  localparam omap_t O_MAP  = {2'd2, 2'd0, 2'd1, 2'd3};

  int unsigned s0_tbl [16] = '{1, 3, 0, 2, 3, 1, 2, 0, 0, 3, 2, 1, 1, 3, 3, 2};
  int unsigned s1_tbl [16] = '{0, 2, 1, 0, 2, 1, 3, 3, 3, 2, 0, 1, 1, 0, 0, 3};

  function automatic logic [7:0] m_perm(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[P8_MAP[i]];
    return r;
  endfunction

  // Inverse permutation derived from the forward map.
  function automatic logic [7:0] m_unperm(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[P8_MAP[i]] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] m_subkey(input logic [9:0] k, input kmap_t m);
    logic [9:0] ki;
    logic [7:0] r;
    ki = ~k;
    for (int i = 0; i < 8; i++) r[i] = ki[m[i]];
    return r;
  endfunction

  function automatic logic [3:0] m_f(input logic [3:0] x, input logic [7:0] k);
    logic [7:0] e;
    logic [3:0] a;
    logic [3:0] r;
    for (int i = 0; i < 8; i++) e[i] = x[E_MAP[i]];
    e = e ^ k;
    a = {2'(s0_tbl[e[7:4]]), 2'(s1_tbl[e[3:0]])};
    for (int i = 0; i < 4; i++) r[i] = a[O_MAP[i]];
    return r;
  endfunction

  function automatic logic [7:0] m_decrypt(input logic [7:0] c, input logic [9:0] k);
    logic [7:0] f;
    logic [3:0] r;
    logic [3:0] l;
    f = m_perm(~c);
    r = f[7:4] ^ m_f(f[3:0], m_subkey(k, K2_MAP));
    l = f[3:0] ^ m_f(r, m_subkey(k, K1_MAP));
    return ~m_unperm({l, r});
  endfunction

  // Combinational ESDES encryptor: the Feistel rounds of m_decrypt run backwards.
  function automatic logic [7:0] m_encrypt(input logic [7:0] p, input logic [9:0] k);
    logic [7:0] lr;
    logic [3:0] l1;
    logic [3:0] h;
    lr = m_perm(~p);
    l1 = lr[7:4] ^ m_f(lr[3:0], m_subkey(k, K1_MAP));
    h  = lr[3:0] ^ m_f(l1, m_subkey(k, K2_MAP));
    return ~m_unperm({h, l1});
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word end to end with out_ready held high; optionally scramble ct/key while busy.
  task automatic run_word(input logic [7:0] c, input logic [9:0] k, input logic [7:0] exp,
                          input bit scramble);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    ct        = c;
    key       = k;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      check("out_valid_early", 32'(out_valid), 32'd0);
      check("busy_in_flight", 32'(busy), 32'd1);
      check("in_ready_in_flight", 32'(in_ready), 32'd0);
      if (scramble) begin
        ct  = 8'($urandom);
        key = 10'($urandom);
      end
      tick();
    end
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("pt", 32'(pt), 32'(exp));
`ifdef ESDES_DEC_SELFCHECK_EN
    check("chk_err_clean", 32'(chk_err), 32'd0);
`endif
    tick();
    check("idle_after_done", 32'(in_ready), 32'd1);
    check("out_valid_cleared", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0] ct;
    logic [9:0] key;
    logic [7:0] pt;
  } vec_t;

  vec_t tbl [8];

  logic [7:0] nonces [7] = '{8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h3C, 8'h81, 8'h7E};
  logic [9:0] keys   [7] = '{10'h000, 10'h3FF, 10'h2A5, 10'h155, 10'h0F0, 10'h30C, 10'h1AB};
  logic [9:0] rt_keys [3] = '{10'h000, 10'h3FF, 10'h2A5};

  initial begin
    logic [7:0] rc;
    logic [9:0] rk;

    tbl[0] = '{ct: 8'h0F, key: 10'h3FF, pt: 8'hFF};
    for (int i = 0; i < 7; i++) begin
      tbl[i+1] = '{ct: m_encrypt(nonces[i], keys[i]), key: keys[i], pt: nonces[i]};
    end

    // Reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct        = 8'h00;
    key       = 10'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pt", 32'(pt), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors
    for (int i = 0; i < 8; i++) run_word(tbl[i].ct, tbl[i].key, tbl[i].pt, 1'b0);

    // Backpressure on the known vector, with a competing in_valid held high
    @(negedge clk);
    ct        = 8'h0F;
    key       = 10'h3FF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    ct  = 8'h55;
    key = 10'h123;
    repeat (LAT) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_pt", 32'(pt), 32'hFF);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset while in R2
    @(negedge clk);
    ct       = 8'h0F;
    key      = 10'h3FF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_pt", 32'(pt), 32'h00);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_valid", 32'(out_valid), 32'd0);
      check("midrst_pt_held", 32'(pt), 32'h00);
    end
    run_word(8'h0F, 10'h3FF, 8'hFF, 1'b0);

    // Round trip through the encryptor, inputs scrambled while busy
    foreach (rt_keys[j]) begin
      for (int n = 0; n < 256; n++) begin
        run_word(m_encrypt(8'(n), rt_keys[j]), rt_keys[j], 8'(n), 1'b1);
      end
    end

    // Random ciphertexts and keys against the model decryptor
    for (int i = 0; i < 200; i++) begin
      rc = 8'($urandom);
      rk = 10'($urandom);
      run_word(rc, rk, m_decrypt(rc, rk), 1'(i % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
